// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the pipelined RISC-V immediate generator.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_CSR   = 3'd7
    } imm_fmt_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;

    // slli/srli/srai (and their W forms) carry a shift amount instead of an I immediate.
    function automatic logic is_shift_funct3(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_gen_if.sv
// Valid/ready bus between decode stage producer/consumer and the immediate generator.
interface imm_gen_if
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) ();

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    imm_fmt_e         out_fmt;
    logic             out_illegal;
    logic [31:0]      out_instr;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush, in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr, out_tag
    );

    modport slave (
        input  flush, in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr, out_tag
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate format decode and extraction.
// Optional IMM_GEN_ZICSR_EN adds CSR immediates (FMT_CSR) for the SYSTEM opcode.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    localparam bit IS_RV64 = (XLEN == 64);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [5:0] shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // RV64 OP-IMM shifts use a 6-bit amount; the W forms and RV32 stay at 5 bits.
    assign shamt = (IS_RV64 && (opcode == OPC_OPIMM)) ? instr[25:20] : {1'b0, instr[24:20]};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        fmt     = FMT_NONE;
        illegal = 1'b1;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                fmt     = FMT_I;
                illegal = 1'b0;
            end
            OPC_OPIMM: begin
                fmt     = is_shift_funct3(funct3) ? FMT_SHAMT : FMT_I;
                illegal = 1'b0;
            end
            OPC_OPIMM32: begin
                if (IS_RV64) begin
                    fmt     = is_shift_funct3(funct3) ? FMT_SHAMT : FMT_I;
                    illegal = 1'b0;
                end
            end
            OPC_STORE: begin
                fmt     = FMT_S;
                illegal = 1'b0;
            end
            OPC_BRANCH: begin
                fmt     = FMT_B;
                illegal = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt     = FMT_U;
                illegal = 1'b0;
            end
            OPC_JAL: begin
                fmt     = FMT_J;
                illegal = 1'b0;
            end
            OPC_OP: begin
                illegal = 1'b0;
            end
`ifdef IMM_GEN_ZICSR_EN
            OPC_SYSTEM: begin
                // csrrwi/csrrsi/csrrci take rs1 as a 5-bit unsigned immediate.
                fmt     = (funct3[2] && (funct3[1:0] != 2'b00)) ? FMT_CSR : FMT_I;
                illegal = 1'b0;
            end
`else
            OPC_SYSTEM: begin
                fmt     = FMT_NONE;
                illegal = 1'b1;
            end
`endif
            default: begin
                fmt     = FMT_NONE;
                illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:     imm = XLEN'($signed(instr[31:20]));
            FMT_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            FMT_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            FMT_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
            FMT_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            FMT_SHAMT: imm = XLEN'(shamt);
            FMT_CSR:   imm = XLEN'(instr[19:15]);
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode in front of a two-entry skid buffer
// with registered valid/ready on both sides and flush on branch redirect.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    imm_gen_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [31:0]      instr;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;
    entry_t          dec;

    entry_t     main_q;
    entry_t     skid_q;
    buf_state_e state;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       in_fire;
    logic       out_fire;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (bus.in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    always_comb begin
        dec = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal,
                instr: bus.in_instr, tag: bus.in_tag};
    end

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    // NOTE: state and payload update with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BUF_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            // NOTE: payload registers are reset because they drive the outputs directly and need defined reset values.
            main_q      <= '0;
            skid_q      <= '0;
        end else if (bus.flush) begin
            state       <= BUF_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (in_fire) begin
                        main_q      <= dec;
                        state       <= BUF_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_q     <= dec;
                        state      <= BUF_FULL;
                        in_ready_q <= 1'b0;
                    end else if (in_fire) begin
                        main_q <= dec;
                    end else if (out_fire) begin
                        state       <= BUF_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                BUF_FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        main_q     <= skid_q;
                        state      <= BUF_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= BUF_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_illegal = main_q.illegal;
    assign bus.out_instr   = main_q.instr;
    assign bus.out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances fed the same stream.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_tag;

    always #5 clk = ~clk;

    imm_gen_if #(.XLEN(32), .TAG_W(32)) b32 ();
    imm_gen_if #(.XLEN(64), .TAG_W(32)) b64 ();

    assign b32.flush = flush;     assign b64.flush = flush;
    assign b32.in_valid = in_valid; assign b64.in_valid = in_valid;
    assign b32.in_instr = in_instr; assign b64.in_instr = in_instr;
    assign b32.in_tag = in_tag;   assign b64.in_tag = in_tag;
    assign b32.out_ready = out_ready; assign b64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] instr;
        logic [31:0] tag;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } vec_t;

    exp_t q32[$];
    exp_t q64[$];
    vec_t vecs[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_state();
        check("rst_out_valid32", 64'(b32.out_valid), 64'd0);
        check("rst_in_ready32", 64'(b32.in_ready), 64'd1);
        check("rst_imm32", 64'(b32.out_imm), 64'd0);
        check("rst_fmt32", 64'(b32.out_fmt), 64'(FMT_NONE));
        check("rst_illegal32", 64'(b32.out_illegal), 64'd0);
        check("rst_instr32", 64'(b32.out_instr), 64'd0);
        check("rst_tag32", 64'(b32.out_tag), 64'd0);
        check("rst_out_valid64", 64'(b64.out_valid), 64'd0);
        check("rst_in_ready64", 64'(b64.in_ready), 64'd1);
        check("rst_imm64", b64.out_imm, 64'd0);
        check("rst_fmt64", 64'(b64.out_fmt), 64'(FMT_NONE));
        check("rst_tag64", 64'(b64.out_tag), 64'd0);
    endtask

    // Presents one instruction until accepted; expectations are queued at the accepting edge.
    task automatic send(input vec_t v, input logic [31:0] tag, input bit check_latency);
        bit acc = 1'b0;
        int budget = 0;
        in_valid = 1'b1;
        in_instr = v.instr;
        in_tag   = tag;
        do begin
            @(negedge clk);
            acc = b32.in_ready;
            if (acc) begin
                q32.push_back('{imm: {32'd0, v.imm32}, fmt: v.fmt32, ill: v.ill32, instr: v.instr, tag: tag});
                q64.push_back('{imm: v.imm64, fmt: v.fmt64, ill: v.ill64, instr: v.instr, tag: tag});
            end
            @(posedge clk);
            #1;
            budget++;
        end while (!acc && budget < 50);
        if (!acc) check("send_timeout_in_ready", 64'(b32.in_ready), 64'd1);
        in_valid = 1'b0;
        if (check_latency) begin
            check("lat_valid32", 64'(b32.out_valid), 64'd1);
            check("lat_tag32", 64'(b32.out_tag), 64'(tag));
            check("lat_valid64", 64'(b64.out_valid), 64'd1);
            check("lat_tag64", 64'(b64.out_tag), 64'(tag));
        end
    endtask

    always @(negedge clk) begin
        automatic exp_t e;
        if (rst_n && out_ready) begin
            if (b32.out_valid) begin
                if (q32.size() == 0) check("spurious32", 64'(b32.out_valid), 64'd0);
                else begin
                    e = q32.pop_front();
                    check("imm32", 64'(b32.out_imm), e.imm);
                    check("fmt32", 64'(b32.out_fmt), 64'(e.fmt));
                    check("illegal32", 64'(b32.out_illegal), 64'(e.ill));
                    check("instr32", 64'(b32.out_instr), 64'(e.instr));
                    check("tag32", 64'(b32.out_tag), 64'(e.tag));
                end
            end
            if (b64.out_valid) begin
                if (q64.size() == 0) check("spurious64", 64'(b64.out_valid), 64'd0);
                else begin
                    e = q64.pop_front();
                    check("imm64", b64.out_imm, e.imm);
                    check("fmt64", 64'(b64.out_fmt), 64'(e.fmt));
                    check("illegal64", 64'(b64.out_illegal), 64'(e.ill));
                    check("instr64", 64'(b64.out_instr), 64'(e.instr));
                    check("tag64", 64'(b64.out_tag), 64'(e.tag));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0; in_tag = '0;

        //          instr         imm32         fmt32      ill  imm64                   fmt64      ill
        vecs.push_back('{32'hFFF00093, 32'hFFFFFFFF, FMT_I,     1'b0, 64'hFFFFFFFFFFFFFFFF, FMT_I,     1'b0});
        vecs.push_back('{32'hFE112E23, 32'hFFFFFFFC, FMT_S,     1'b0, 64'hFFFFFFFFFFFFFFFC, FMT_S,     1'b0});
        vecs.push_back('{32'h0080006F, 32'h00000008, FMT_J,     1'b0, 64'h0000000000000008, FMT_J,     1'b0});
        vecs.push_back('{32'h123452B7, 32'h12345000, FMT_U,     1'b0, 64'h0000000012345000, FMT_U,     1'b0});
        vecs.push_back('{32'h00309093, 32'h00000003, FMT_SHAMT, 1'b0, 64'h0000000000000003, FMT_SHAMT, 1'b0});
        vecs.push_back('{32'h03F09093, 32'h0000001F, FMT_SHAMT, 1'b0, 64'h000000000000003F, FMT_SHAMT, 1'b0});
        vecs.push_back('{32'h0000001B, 32'h00000000, FMT_NONE,  1'b1, 64'h0000000000000000, FMT_I,     1'b0});
        vecs.push_back('{32'h0030909B, 32'h00000000, FMT_NONE,  1'b1, 64'h0000000000000003, FMT_SHAMT, 1'b0});
        vecs.push_back('{32'h00000000, 32'h00000000, FMT_NONE,  1'b1, 64'h0000000000000000, FMT_NONE,  1'b1});
        vecs.push_back('{32'h00000033, 32'h00000000, FMT_NONE,  1'b0, 64'h0000000000000000, FMT_NONE,  1'b0});
        vecs.push_back('{32'hFE000EE3, 32'hFFFFFFFC, FMT_B,     1'b0, 64'hFFFFFFFFFFFFFFFC, FMT_B,     1'b0});
        vecs.push_back('{32'h80000017, 32'h80000000, FMT_U,     1'b0, 64'hFFFFFFFF80000000, FMT_U,     1'b0});
        vecs.push_back('{32'h7FF02083, 32'h000007FF, FMT_I,     1'b0, 64'h00000000000007FF, FMT_I,     1'b0});
        vecs.push_back('{32'h4030D093, 32'h00000003, FMT_SHAMT, 1'b0, 64'h0000000000000003, FMT_SHAMT, 1'b0});
        vecs.push_back('{32'h00008067, 32'h00000000, FMT_I,     1'b0, 64'h0000000000000000, FMT_I,     1'b0});
`ifdef IMM_GEN_ZICSR_EN
        vecs.push_back('{32'h01FFD073, 32'h0000001F, FMT_CSR,   1'b0, 64'h000000000000001F, FMT_CSR,   1'b0});
        vecs.push_back('{32'h01F05073, 32'h00000000, FMT_CSR,   1'b0, 64'h0000000000000000, FMT_CSR,   1'b0});
        vecs.push_back('{32'h30001073, 32'h00000300, FMT_I,     1'b0, 64'h0000000000000300, FMT_I,     1'b0});
`else
        vecs.push_back('{32'h01FFD073, 32'h00000000, FMT_NONE,  1'b1, 64'h0000000000000000, FMT_NONE,  1'b1});
        vecs.push_back('{32'h01F05073, 32'h00000000, FMT_NONE,  1'b1, 64'h0000000000000000, FMT_NONE,  1'b1});
        vecs.push_back('{32'h30001073, 32'h00000000, FMT_NONE,  1'b1, 64'h0000000000000000, FMT_NONE,  1'b1});
`endif

        // Reset values.
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stream with out_ready high: one-cycle latency, one per cycle.
        foreach (vecs[i]) send(vecs[i], 32'h100 + i, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: consumer stalls three cycles while four instructions are offered.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(vecs[i], 32'h200 + i, 1'b0);
                    if (i == 1) begin
                        check("bp_in_ready32", 64'(b32.in_ready), 64'd0);
                        check("bp_in_ready64", 64'(b64.in_ready), 64'd0);
                    end
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;

        // Flush while FULL with a simultaneous input that must be discarded.
        out_ready = 1'b0;
        send(vecs[0], 32'h300, 1'b0);
        send(vecs[1], 32'h301, 1'b0);
        check("pre_flush_in_ready32", 64'(b32.in_ready), 64'd0);
        in_valid = 1'b1;
        in_instr = vecs[2].instr;
        in_tag   = 32'h3FF;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid32", 64'(b32.out_valid), 64'd0);
        check("flush_in_ready32", 64'(b32.in_ready), 64'd1);
        check("flush_out_valid64", 64'(b64.out_valid), 64'd0);
        check("flush_in_ready64", 64'(b64.in_ready), 64'd1);
        q32.delete();
        q64.delete();
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_flush_idle32", 64'(b32.out_valid), 64'd0);
        send(vecs[3], 32'h310, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a FULL buffer.
        out_ready = 1'b0;
        send(vecs[4], 32'h400, 1'b0);
        send(vecs[1], 32'h401, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state();
        q32.delete();
        q64.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(vecs[11], 32'h500, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        check("leftover32", 64'(q32.size()), 64'd0);
        check("leftover64", 64'(q64.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
